// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM encoding, mode constants and defaults for mem_backend
package mem_pkg;

  // FSM encoding kept as plain constants so legacy netlists can match state values.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int DEFAULT_SIZE_RAM = 4096;

  // Latency counter width; LATENCY-1 never exceeds 254.
  localparam int CNT_W = 8;

endpackage

// File: rtl/mem_backend_array.sv
// rtl/mem_backend_array.sv - single-port word array, synchronous write, no reset
//
// Ports:
//   clk   - write clock
//   we    - write enable for the current cycle
//   addr  - shared read/write word address
//   wdata - write data
//   rdata - contents of the addressed word
module mem_backend_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_backend.sv
// rtl/mem_backend.sv - fixed-latency memory backend behind a req/done handshake
//
// Optional feature macro: MEM_BACKEND_STATS_EN (adds rd_count / wr_count).
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   req      - start strobe, only looked at while idle
//   mode     - 0 read, 1 write
//   address  - word address, taken modulo SIZE_RAM
//   data     - write data
//   response - 1 while an operation is in flight
//   out      - last read data, held until the next read completes
//   done     - one-cycle completion pulse
//   rd_count - completed reads, saturating (MEM_BACKEND_STATS_EN only)
//   wr_count - completed writes, saturating (MEM_BACKEND_STATS_EN only)
module mem_backend
  import mem_pkg::*;
#(
  parameter int SIZE_RAM = DEFAULT_SIZE_RAM,
  parameter int LATENCY  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        mode,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic        response,
  output logic [31:0] out,
  output logic        done
`ifdef MEM_BACKEND_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int AW = $clog2(SIZE_RAM);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      out_q, out_d;
  logic [31:0]      rd_data;
  logic             complete;
  logic             mem_we;

  // Upper address bits are discarded by design; the fold only keeps them referenced.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:AW];

  // The completing edge is the one that sees BUSY with an exhausted counter.
  assign complete = (state_q == ST_BUSY) && (cnt_q == '0);
  assign mem_we   = complete && (mode_q == MODE_WRITE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    data_d  = data_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_LOAD;
          mode_d  = mode;
          addr_d  = address[AW-1:0];
          data_d  = data;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_DONE;
          if (mode_q == MODE_READ) begin
            out_d = rd_data;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_READ;
      addr_q  <= '0;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end

  // Writes happen only on the completing edge, so a reset mid-operation leaves the array untouched.
  mem_backend_array #(
    .DEPTH (SIZE_RAM),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (rd_data)
  );

  assign response = (state_q == ST_BUSY);
  assign done     = (state_q == ST_DONE);
  assign out      = out_q;

`ifdef MEM_BACKEND_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (complete) begin
      if (mode_q == MODE_READ) begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end else begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule
